// File: rtl/conv_window_sched.sv
// Window sequencer for the binary-kernel convolution datapath: walks every valid
// MxM window of an NxN image, issues one pixel read per tap and emits masked sums.
module conv_window_sched #(
  parameter  int M  = 3,
  parameter  int N  = 8,
  parameter  int PW = 8,
  parameter  int OW = 12,
  localparam int AW = $clog2(N*N),
  localparam int RW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          start,
  input  logic [M*M-1:0] kernel,
  output logic          busy,
  output logic          rd_en,
  output logic [AW-1:0] rd_addr,
  input  logic [PW-1:0] rd_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [OW-1:0] out,
  output logic [RW-1:0] out_row,
  output logic [RW-1:0] out_col,
  output logic          finish
);

  localparam int MM = M * M;
  localparam int KW = $clog2(MM);
  localparam int TW = $clog2(M);

  typedef enum logic [2:0] {IDLE, FETCH, LAST, OUT, DONE} state_t;

  state_t         state;
  logic [MM-1:0]  kern;
  logic [RW-1:0]  r;
  logic [RW-1:0]  c;
  logic [KW-1:0]  k;
  logic [TW-1:0]  ti;
  logic [TW-1:0]  tj;
  logic [OW-1:0]  acc;

  logic [TW-1:0]  ti_n;
  logic [TW-1:0]  tj_n;
  logic [RW-1:0]  nr;
  logic [RW-1:0]  nc;
  logic           last_row;
  logic           last_col;
  logic [KW-1:0]  tap_sel;
  logic           add_en;
  logic [OW-1:0]  add_val;

  function automatic logic [AW-1:0] addr_of(input logic [RW-1:0] row,
                                            input logic [RW-1:0] col,
                                            input logic [TW-1:0] di,
                                            input logic [TW-1:0] dj);
    return (AW'(row) + AW'(di)) * AW'(N) + AW'(col) + AW'(dj);
  endfunction

  // Tap position following (ti, tj) in row-major kernel order
  always_comb begin
    tj_n = tj + TW'(1);
    ti_n = ti;
    if (tj == TW'(M - 1)) begin
      tj_n = '0;
      ti_n = ti + TW'(1);
    end
  end

  always_comb begin
    last_row = (r == RW'(N - M));
    last_col = (c == RW'(N - M));
    nr       = last_col ? r + RW'(1) : r;
    nc       = last_col ? '0 : c + RW'(1);
  end

  // rd_data belongs to the tap issued one cycle earlier; in LAST k still names the final tap
  always_comb begin
    tap_sel = (state == LAST) ? k : k - KW'(1);
    add_en  = ((state == FETCH) && (k != '0)) || (state == LAST);
    add_val = (add_en && kern[tap_sel]) ? OW'(rd_data) : '0;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      busy      <= 1'b0;
      rd_en     <= 1'b0;
      rd_addr   <= '0;
      out_valid <= 1'b0;
      out       <= '0;
      out_row   <= '0;
      out_col   <= '0;
      finish    <= 1'b0;
      kern      <= '0;
      r         <= '0;
      c         <= '0;
      k         <= '0;
      ti        <= '0;
      tj        <= '0;
      acc       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            kern    <= kernel;
            r       <= '0;
            c       <= '0;
            k       <= '0;
            ti      <= '0;
            tj      <= '0;
            acc     <= '0;
            busy    <= 1'b1;
            rd_en   <= 1'b1;
            rd_addr <= '0;
            state   <= FETCH;
          end
        end
        FETCH: begin
          acc <= acc + add_val;
          if (k == KW'(MM - 1)) begin
            rd_en <= 1'b0;
            state <= LAST;
          end else begin
            k       <= k + KW'(1);
            ti      <= ti_n;
            tj      <= tj_n;
            rd_addr <= addr_of(r, c, ti_n, tj_n);
          end
        end
        LAST: begin
          out       <= acc + add_val;
          out_valid <= 1'b1;
          out_row   <= r;
          out_col   <= c;
          state     <= OUT;
        end
        OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (last_row && last_col) begin
              finish <= 1'b1;
              state  <= DONE;
            end else begin
              r       <= nr;
              c       <= nc;
              k       <= '0;
              ti      <= '0;
              tj      <= '0;
              acc     <= '0;
              rd_en   <= 1'b1;
              rd_addr <= addr_of(nr, nc, TW'(0), TW'(0));
              state   <= FETCH;
            end
          end
        end
        DONE: begin
          finish <= 1'b0;
          busy   <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_window_sched.sv
// Directed bench for conv_window_sched: behavioural pixel memory plus per-scenario tasks.
module tb_conv_window_sched;
  localparam int M  = 3;
  localparam int N  = 8;
  localparam int PW = 8;
  localparam int OW = 12;
  localparam int AW = 6;
  localparam int RW = 3;
  localparam int NW = (N - M + 1) * (N - M + 1);
  localparam logic [8:0] MIXED = 9'b101011101;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          start = 1'b0;
  logic [8:0]    kernel = '0;
  logic          busy;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [PW-1:0] rd_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [OW-1:0] out;
  logic [RW-1:0] out_row;
  logic [RW-1:0] out_col;
  logic          finish;

  int vectors = 0;
  int errors  = 0;

  logic [PW-1:0] mem [N*N];
  logic [OW-1:0] res_out [64];
  logic [RW-1:0] res_row [64];
  logic [RW-1:0] res_col [64];
  int            nres;
  int            busy_cycles;
  int            fin_cnt;
  int            stall_bad;
  int            stall_cycles;
  logic [OW-1:0] stall_out;
  logic [RW-1:0] stall_row;
  logic [RW-1:0] stall_col;

  conv_window_sched #(.M(M), .N(N), .PW(PW), .OW(OW)) dut (
    .clk(clk), .rstn(rstn), .start(start), .kernel(kernel), .busy(busy),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .out_valid(out_valid), .out_ready(out_ready), .out(out),
    .out_row(out_row), .out_col(out_col), .finish(finish)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

  task automatic fill_ramp;
    for (int a = 0; a < N*N; a++) mem[a] = PW'(a);
  endtask

  task automatic fill_const(input logic [PW-1:0] v);
    for (int a = 0; a < N*N; a++) mem[a] = v;
  endtask

  // Runs one job to completion, recording every accepted result.
  task automatic run_job(input logic [8:0] kern, input bit stall_en,
                         input bit poke_en, input bit start_on_finish);
    int stall_left = 0;
    bit stalled = 0;
    bit seen_busy = 0;
    int cyc = 0;
    nres = 0; busy_cycles = 0; fin_cnt = 0; stall_bad = 0; stall_cycles = 0;
    stall_out = '0; stall_row = '1; stall_col = '1;
    @(negedge clk);
    kernel = kern; start = 1'b1; out_ready = 1'b1;
    while (cyc < 3000) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      if (poke_en && cyc == 50) begin
        start  = 1'b1;
        kernel = '0;
      end
      if (finish) begin
        fin_cnt++;
        if (start_on_finish) start = 1'b1;
      end
      if (busy) begin
        busy_cycles++;
        seen_busy = 1;
      end else if (seen_busy) begin
        break;
      end
      if (stall_left > 0) begin
        stall_cycles++;
        if (!out_valid || out !== stall_out || out_row !== stall_row ||
            out_col !== stall_col || rd_en) stall_bad++;
        stall_left--;
        if (stall_left == 0) out_ready = 1'b1;
      end else if (stall_en && !stalled && out_valid && out_row == 0 && out_col == 1) begin
        stall_out = out; stall_row = out_row; stall_col = out_col;
        out_ready = 1'b0; stalled = 1; stall_left = 5;
      end
      if (out_valid && out_ready && nres < 64) begin
        res_out[nres] = out; res_row[nres] = out_row; res_col[nres] = out_col;
        nres++;
      end
    end
    start = 1'b0;
    out_ready = 1'b1;
    vectors++;
    if (cyc >= 3000) begin
      errors++;
      $display("FAIL job_timeout: busy still %0b after %0d cycles, required completion", busy, cyc);
    end
  endtask

  task automatic test_reset;
    kernel = 9'h1FF; start = 1'b1; rstn = 1'b0;
    repeat (2) @(negedge clk);
    vectors++;
    if ({busy, rd_en, out_valid, finish} !== 4'b0 || rd_addr !== '0 || out !== '0 ||
        out_row !== '0 || out_col !== '0) begin
      errors++;
      $display("FAIL reset_outputs: busy=%b rd_en=%b valid=%b finish=%b addr=%0d out=%0d row=%0d col=%0d, required all 0",
               busy, rd_en, out_valid, finish, rd_addr, out, out_row, out_col);
    end
    start = 1'b0;
    rstn = 1'b1;
    repeat (2) @(negedge clk);
    vectors++;
    if (busy !== 1'b0 || rd_en !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: busy=%b rd_en=%b, required 0 0", busy, rd_en);
    end
  endtask

  task automatic test_ramp_mixed;
    fill_ramp();
    run_job(MIXED, 0, 0, 0);
    vectors++;
    if (nres !== NW) begin
      errors++;
      $display("FAIL ramp_count: got %0d results, required %0d", nres, NW);
    end
    for (int i = 0; i < NW; i++) begin
      vectors++;
      if (res_out[i] !== OW'(53 + 6*(8*(i/6) + i%6)) || res_row[i] !== RW'(i/6) ||
          res_col[i] !== RW'(i%6)) begin
        errors++;
        $display("FAIL ramp_window%0d: got %0d at (%0d,%0d), required %0d at (%0d,%0d)",
                 i, res_out[i], res_row[i], res_col[i], 53 + 6*(8*(i/6) + i%6), i/6, i%6);
      end
    end
    vectors++;
    if (fin_cnt !== 1) begin
      errors++;
      $display("FAIL ramp_finish: got %0d finish pulses, required 1", fin_cnt);
    end
    vectors++;
    if (busy_cycles !== 397) begin
      errors++;
      $display("FAIL ramp_busy_cycles: got %0d, required 397", busy_cycles);
    end
  endtask

  task automatic test_saturation;
    fill_const(8'hFF);
    run_job(9'h1FF, 0, 0, 0);
    vectors++;
    if (nres !== NW) begin
      errors++;
      $display("FAIL sat_count: got %0d results, required %0d", nres, NW);
    end
    for (int i = 0; i < NW; i++) begin
      vectors++;
      if (res_out[i] !== 12'd2295) begin
        errors++;
        $display("FAIL sat_window%0d: got %0d, required 2295", i, res_out[i]);
      end
    end
  endtask

  task automatic test_zero_kernel;
    int idle_bad = 0;
    fill_ramp();
    run_job(9'h000, 0, 0, 1);
    vectors++;
    if (nres !== NW) begin
      errors++;
      $display("FAIL zero_count: got %0d results, required %0d", nres, NW);
    end
    for (int i = 0; i < NW; i++) begin
      vectors++;
      if (res_out[i] !== '0) begin
        errors++;
        $display("FAIL zero_window%0d: got %0d, required 0", i, res_out[i]);
      end
    end
    repeat (3) begin
      @(negedge clk);
      if (busy || rd_en) idle_bad++;
    end
    vectors++;
    if (idle_bad !== 0) begin
      errors++;
      $display("FAIL start_at_finish: busy seen in %0d idle cycles, required 0", idle_bad);
    end
  endtask

  task automatic test_backpressure;
    fill_ramp();
    run_job(MIXED, 1, 0, 0);
    vectors++;
    if (stall_out !== 12'd59 || stall_row !== 3'd0 || stall_col !== 3'd1) begin
      errors++;
      $display("FAIL stall_window: got %0d at (%0d,%0d), required 59 at (0,1)", stall_out, stall_row, stall_col);
    end
    vectors++;
    if (stall_cycles !== 5 || stall_bad !== 0) begin
      errors++;
      $display("FAIL stall_stable: %0d unstable of %0d stall cycles, required 0 of 5", stall_bad, stall_cycles);
    end
    vectors++;
    if (busy_cycles !== 402) begin
      errors++;
      $display("FAIL stall_busy_cycles: got %0d, required 402", busy_cycles);
    end
    vectors++;
    if (nres !== NW || res_out[1] !== 12'd59 || res_out[NW-1] !== 12'd323) begin
      errors++;
      $display("FAIL stall_results: got %0d results, w1=%0d last=%0d, required %0d, 59, 323",
               nres, res_out[1], res_out[NW-1], NW);
    end
  endtask

  task automatic test_busy_protection;
    fill_ramp();
    run_job(MIXED, 0, 1, 0);
    vectors++;
    if (nres !== NW || fin_cnt !== 1 || busy_cycles !== 397) begin
      errors++;
      $display("FAIL protect_job: results=%0d finish=%0d busy=%0d, required %0d 1 397",
               nres, fin_cnt, busy_cycles, NW);
    end
    for (int i = 0; i < NW; i++) begin
      vectors++;
      if (res_out[i] !== OW'(53 + 6*(8*(i/6) + i%6))) begin
        errors++;
        $display("FAIL protect_window%0d: got %0d, required %0d", i, res_out[i], 53 + 6*(8*(i/6) + i%6));
      end
    end
  endtask

  task automatic test_reset_mid_job;
    int fins = 0;
    fill_ramp();
    @(negedge clk);
    kernel = MIXED; start = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (37) begin
      @(negedge clk);
      if (finish) fins++;
    end
    vectors++;
    if (rd_en !== 1'b1 || rd_addr !== 6'd12) begin
      errors++;
      $display("FAIL midjob_tap: rd_en=%b addr=%0d, required 1 12", rd_en, rd_addr);
    end
    #2 rstn = 1'b0;
    #1;
    vectors++;
    if ({busy, rd_en, out_valid, finish} !== 4'b0 || rd_addr !== '0 || out !== '0 ||
        out_row !== '0 || out_col !== '0) begin
      errors++;
      $display("FAIL async_reset: busy=%b rd_en=%b valid=%b finish=%b addr=%0d out=%0d row=%0d col=%0d, required all 0",
               busy, rd_en, out_valid, finish, rd_addr, out, out_row, out_col);
    end
    @(negedge clk);
    rstn = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (finish || busy) fins++;
    end
    vectors++;
    if (fins !== 0) begin
      errors++;
      $display("FAIL abort_no_finish: got %0d finish/busy cycles, required 0", fins);
    end
    run_job(MIXED, 0, 0, 0);
    vectors++;
    if (nres !== NW || res_out[0] !== 12'd53 || res_row[0] !== 3'd0 || res_col[0] !== 3'd0) begin
      errors++;
      $display("FAIL restart_first: got %0d results, first %0d at (%0d,%0d), required %0d, 53 at (0,0)",
               nres, res_out[0], res_row[0], res_col[0], NW);
    end
  endtask

  initial begin
    test_reset();
    test_ramp_mixed();
    test_saturation();
    test_zero_kernel();
    test_backpressure();
    test_busy_protection();
    test_reset_mid_job();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
